// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a variable-latency
// instruction memory, buffers returned words in order and hands them to IF/ID.
// Credit-based issue guarantees every response has a free slot; redirects
// flush the buffer and mark in-flight fetches to be dropped on return.
module inst_fetch_queue #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       rom_req_o,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic                       rom_gnt_i,
    input  logic                       rom_rvalid_i,
    input  logic [DATA_W-1:0]          rom_rdata_i,
    output logic                       inst_valid_o,
    output logic [ADDR_W-1:0]          inst_pc_o,
    output logic [DATA_W-1:0]          inst_o,
    input  logic                       inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int AF_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic              started;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  outstanding_next;
    logic [OUT_W-1:0]  drop;

    logic [ADDR_W-1:0] af_mem [MAX_OUT];
    logic [AF_W-1:0]   af_rd;
    logic [AF_W-1:0]   af_wr;

    logic              grant;
    logic              resp_ok;
    logic              enq;
    logic              deq;
    logic [CNT_W:0]    used;

    // Address FIFO pointers wrap at MAX_OUT, which need not be a power of two
    function automatic logic [AF_W-1:0] af_next(input logic [AF_W-1:0] p);
        if (p == AF_W'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + AF_W'(1);
    endfunction

    // Handshake qualifiers, credit check and net counter changes
    always_comb begin
        used      = (CNT_W + 1)'(count) + (CNT_W + 1)'(outstanding);
        rom_req_o = started && !redirect_i
                    && (outstanding < OUT_W'(MAX_OUT))
                    && (used < (CNT_W + 1)'(DEPTH));
        grant     = rom_req_o && rom_gnt_i;
        resp_ok   = rom_rvalid_i && (outstanding != '0);
        enq       = resp_ok && (drop == '0) && !redirect_i;
        deq       = (count != '0) && inst_ready_i && !redirect_i;

        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase

        outstanding_next = outstanding;
        case ({grant, resp_ok})
            2'b10:   outstanding_next = outstanding + OUT_W'(1);
            2'b01:   outstanding_next = outstanding - OUT_W'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    assign rom_addr_o   = fetch_pc;
    assign inst_valid_o = (count != '0);
    assign inst_pc_o    = pc_mem[rd_ptr];
    assign inst_o       = inst_mem[rd_ptr];
    assign count_o      = count;

    // Fetch address, in-flight bookkeeping and drop accounting for redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            af_rd       <= '0;
            af_wr       <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
            end else if (grant) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            // Every request still in flight after a redirect is stale,
            // including any that were already doomed by an earlier redirect
            if (redirect_i) begin
                drop <= outstanding_next;
            end else if (resp_ok && (drop != '0)) begin
                drop <= drop - OUT_W'(1);
            end
            if (grant) begin
                af_wr <= af_next(af_wr);
            end
            if (resp_ok) begin
                af_rd <= af_next(af_rd);
            end
        end
    end

    // Address FIFO storage remembers the PC of each outstanding request
    always_ff @(posedge clk) begin
        if (grant) begin
            af_mem[af_wr] <= fetch_pc;
        end
    end

    // Instruction buffer: enqueue accepted responses, dequeue to IF/ID, flush on redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (enq) begin
                pc_mem[wr_ptr]   <= af_mem[af_rd];
                inst_mem[wr_ptr] <= rom_rdata_i;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue with an in-order memory model and a
// queue-based reference of fetched, in-flight and buffered instructions.
module tb_inst_fetch_queue;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect_i = 1'b0;
    logic [ADDR_W-1:0] redirect_pc_i = '0;
    logic              rom_req_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_gnt_i = 1'b0;
    logic              rom_rvalid_i = 1'b0;
    logic [DATA_W-1:0] rom_rdata_i = '0;
    logic              inst_valid_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic [DATA_W-1:0] inst_o;
    logic              inst_ready_i = 1'b0;
    logic [2:0]        count_o;

    inst_fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
        .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o), .inst_o(inst_o),
        .inst_ready_i(inst_ready_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit doomed; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    flight_t     inflight[$];
    entry_t      fifo_m[$];
    mem_t        mem_q[$];
    logic [31:0] fetch_m;
    bit          started_m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int since_reset = 0;
    int orphans = 0;
    int grants = 0;
    int ndeq = 0;
    int first_valid = -1;
    int p_gnt = 100, p_ready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit force_redir = 0;
    logic [31:0] force_pc = '0;
    bit track_first = 0;
    bit seen_first = 0;
    logic [31:0] first_pc = '0;

    // Memory contents: a scrambled function of the word address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model
    task automatic applyStimulus();
        logic    rv;
        logic    req_m;
        bit      deq_m;
        flight_t h;
        redirect_i    = force_redir ? 1'b1 : ($urandom_range(0, 99) < p_redir);
        redirect_pc_i = force_redir ? force_pc : (32'($urandom_range(0, 1023)) << 2);
        force_redir   = 0;
        rom_gnt_i     = (orphans == 0) && ($urandom_range(0, 99) < p_gnt);
        inst_ready_i  = ($urandom_range(0, 99) < p_ready);
        rv            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rom_rvalid_i  = rv;
        rom_rdata_i   = rv ? word_of(mem_q[0].addr) : $urandom();
        #1;
        req_m = started_m && !redirect_i && (inflight.size() < MAX_OUT)
                && ((fifo_m.size() + inflight.size()) < DEPTH);
        checkOutput("rom_req", rom_req_o, req_m);
        if (req_m) checkOutput("rom_addr", rom_addr_o, fetch_m);
        checkOutput("inst_valid", inst_valid_o, fifo_m.size() != 0);
        checkOutput("count", count_o, fifo_m.size());
        if (fifo_m.size() != 0) begin
            checkOutput("inst_pc", inst_pc_o, fifo_m[0].pc);
            checkOutput("inst", inst_o, fifo_m[0].inst);
        end
        if (inst_valid_o && first_valid < 0) first_valid = since_reset;

        // Memory side reacts to what the DUT actually does
        if (rv) mem_q.pop_front();
        if (rom_req_o && rom_gnt_i) begin
            grants++;
            mem_q.push_back('{rom_addr_o, cyc + int'($urandom_range(lat_min, lat_max))});
        end

        // Reference model
        deq_m = inst_ready_i && (fifo_m.size() != 0) && !redirect_i;
        if (deq_m) begin
            if (track_first && !seen_first) begin
                first_pc   = fifo_m[0].pc;
                seen_first = 1;
            end
            void'(fifo_m.pop_front());
            ndeq++;
        end
        if (rv) begin
            if (orphans > 0) begin
                orphans--;
            end else if (inflight.size() > 0) begin
                h = inflight.pop_front();
                if (!redirect_i && !h.doomed) fifo_m.push_back('{h.pc, word_of(h.pc)});
            end
        end
        if (req_m && rom_gnt_i) begin
            inflight.push_back('{fetch_m, 1'b0});
            fetch_m = fetch_m + 32'd4;
        end
        if (redirect_i) begin
            fifo_m.delete();
            foreach (inflight[i]) inflight[i].doomed = 1;
            fetch_m = redirect_pc_i;
        end
        started_m = 1;
        cyc++;
        since_reset++;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, check outputs clear at once, then release
    task automatic doReset();
        rst          = 1'b0;
        redirect_i   = 1'b0;
        rom_gnt_i    = 1'b0;
        rom_rvalid_i = 1'b0;
        inst_ready_i = 1'b0;
        #1;
        checkOutput("rst_req", rom_req_o, 0);
        checkOutput("rst_valid", inst_valid_o, 0);
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_addr", rom_addr_o, RESET_PC);
        checkOutput("rst_inst_pc", inst_pc_o, 0);
        checkOutput("rst_inst", inst_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        inflight.delete();
        fifo_m.delete();
        orphans     = mem_q.size();
        fetch_m     = RESET_PC;
        started_m   = 0;
        since_reset = 0;
        first_valid = -1;
    endtask

    initial begin
        #2;
        doReset();

        // Back-to-back streaming with single-cycle memory
        p_gnt = 100; p_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        ndeq = 0; track_first = 1; seen_first = 0;
        repeat (20) applyStimulus();
        checkOutput("stream_first_valid_cycle", first_valid, 3);
        checkOutput("stream_dequeues", ndeq, 17);
        checkOutput("stream_first_pc", first_pc, RESET_PC);
        track_first = 0;

        // Stalled consumer fills the queue, one dequeue frees one credit
        doReset();
        p_ready = 0; grants = 0;
        repeat (12) applyStimulus();
        checkOutput("full_grants", grants, DEPTH);
        checkOutput("full_count", count_o, DEPTH);
        checkOutput("full_req", rom_req_o, 0);
        p_ready = 100;
        applyStimulus();
        p_ready = 0;
        repeat (6) applyStimulus();
        checkOutput("full_one_more_grant", grants, DEPTH + 1);

        // Redirect with two requests in flight discards both
        doReset();
        p_ready = 100; lat_min = 5; lat_max = 5;
        force_redir = 1; force_pc = 32'h10;
        applyStimulus();
        grants = 0;
        for (int i = 0; i < 20 && grants < 2; i++) applyStimulus();
        checkOutput("redir_two_grants", grants, 2);
        force_redir = 1; force_pc = 32'h100;
        lat_min = 1; lat_max = 3; track_first = 1; seen_first = 0;
        repeat (20) applyStimulus();
        checkOutput("redir_seen", seen_first, 1);
        checkOutput("redir_first_pc", first_pc, 32'h100);
        track_first = 0;

        // Variable latency, wrap-around, then mixed with redirects
        doReset();
        p_gnt = 70; p_ready = 60; lat_min = 1; lat_max = 5; ndeq = 0;
        repeat (600) applyStimulus();
        checkOutput("wraps", ndeq >= 3 * DEPTH, 1);
        p_gnt = 80; p_ready = 70; p_redir = 10;
        repeat (1500) applyStimulus();

        // Reset in the middle of traffic with requests outstanding
        p_redir = 0; p_ready = 0; p_gnt = 100; lat_min = 3; lat_max = 4;
        repeat (6) applyStimulus();
        doReset();
        p_ready = 50; lat_min = 1; lat_max = 5;
        repeat (40) applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
